// File: rtl/t03_sprite_frame_loader_if.sv
// Sprite memory word-read bus: the loader drives a request and address,
// memory answers with a one-cycle ack and the data word.
interface t03_sprite_frame_loader_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/t03_sprite_frame_loader.sv
// Player sprite frame loader.
// At the vblank line the selected animation frame is fetched word by word
// into a shadow buffer; the shadow is committed to the displayed bitmap only
// at the next frame start, so the display never shows a half-loaded sprite.
module t03_sprite_frame_loader #(
    parameter int WORD_W      = 32,
    parameter int SPR_BITS    = 2400,
    parameter int WORDS       = SPR_BITS / WORD_W,
    parameter int ADDR_W      = 12,
    parameter int BASE_ADDR   = 0,
    parameter int VBLANK_LINE = 601
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [10:0]             Hcnt,
    input  logic [10:0]             Vcnt,
    input  logic                    enable,
    input  logic [2:0]              frame_sel,
    t03_sprite_frame_loader_if.master mem,
    output logic [SPR_BITS-1:0]     player,
    output logic [2:0]              frame_cur,
    output logic                    busy,
    output logic                    overrun
);

    localparam int                CNT_W     = $clog2(WORDS);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [10:0]       VB_LINE   = 11'(VBLANK_LINE);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WORDS_A   = ADDR_W'(WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t              state_r;
    logic [2:0]          sel_r;
    logic [CNT_W-1:0]    word_cnt_r;
    logic [SPR_BITS-1:0] shadow_r;
    logic                valid_r;

    logic                trigger_s;
    logic                commit_s;
    logic [ADDR_W-1:0]   start_addr_s;

    // Raster event decode and first word address of the requested frame
    // (address arithmetic deliberately wraps at ADDR_W bits).
    always_comb begin
        trigger_s    = (Vcnt == VB_LINE) && (Hcnt == 11'd0);
        commit_s     = (Vcnt == 11'd0) && (Hcnt == 11'd0);
        start_addr_s = BASE + (ADDR_W'(frame_sel) * WORDS_A);
    end

    // Fetch/commit sequencer; every output is a register of this block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sel_r        <= 3'd0;
            word_cnt_r   <= '0;
            shadow_r     <= '0;
            valid_r      <= 1'b0;
            player       <= '0;
            frame_cur    <= 3'd0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
        end else begin
            overrun <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (trigger_s && enable) begin
                        sel_r <= frame_sel;
                        // Frame already on display: no memory traffic needed.
                        if (!(valid_r && (frame_sel == frame_cur))) begin
                            word_cnt_r   <= '0;
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= start_addr_s;
                            busy         <= 1'b1;
                            state_r      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (trigger_s) begin
                        overrun <= 1'b1;
                    end
                    if (mem.mem_ack) begin
                        // Words arrive in order, so shifting in from the bottom
                        // leaves word k at bits [SPR_BITS-1-WORD_W*k -: WORD_W]
                        // once the last word is in.
                        shadow_r <= {shadow_r[SPR_BITS-WORD_W-1:0], mem.mem_rdata};
                        if (word_cnt_r < LAST_WORD) begin
                            word_cnt_r   <= word_cnt_r + CNT_ONE;
                            mem.mem_addr <= mem.mem_addr + ADDR_ONE;
                        end else begin
                            mem.mem_req <= 1'b0;
                            state_r     <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (trigger_s) begin
                        overrun <= 1'b1;
                    end
                    if (commit_s) begin
                        player    <= shadow_r;
                        frame_cur <= sel_r;
                        valid_r   <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    mem.mem_req <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t03_sprite_frame_loader.sv
// Directed bench for the sprite frame loader: a memory responder with
// configurable ack delay checks request addresses against a scoreboard,
// and the main sequence checks commits against locally built images.
module tb_t03_sprite_frame_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   Hcnt;
    logic [10:0]   Vcnt;
    logic          enable;
    logic [2:0]    frame_sel;
    logic [2399:0] player;
    logic [2:0]    frame_cur;
    logic          busy;
    logic          overrun;

    t03_sprite_frame_loader_if mem_bus ();

    t03_sprite_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .Hcnt      (Hcnt),
        .Vcnt      (Vcnt),
        .enable    (enable),
        .frame_sel (frame_sel),
        .mem       (mem_bus),
        .player    (player),
        .frame_cur (frame_cur),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int        ack_max   = 0;
    bit        stall     = 1'b0;
    int        wait_left = 0;
    logic      prev_req  = 1'b0;
    logic      prev_ack  = 1'b0;
    logic [11:0] prev_addr = 12'd0;
    logic [11:0] exp_addr[$];

    function automatic logic [31:0] mem_data(input logic [11:0] a);
        return {a, ~a, 8'h5A};
    endfunction

    function automatic logic [2399:0] image(input int sel);
        logic [2399:0] img;
        img = '0;
        for (int k = 0; k < 75; k++) begin
            img[2399-32*k -: 32] = mem_data(12'(sel * 75 + k));
        end
        return img;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_player(input string tag, input logic [2399:0] exp);
        int bad;
        bad = 0;
        for (int k = 74; k >= 0; k--) begin
            if (player[2399-32*k -: 32] !== exp[2399-32*k -: 32]) bad = k;
        end
        vectors++;
        assert (player === exp) else begin
            miscompares++;
            $error("FAIL %s: observed word %0d = %h expected %h", tag, bad,
                   player[2399-32*bad -: 32], exp[2399-32*bad -: 32]);
        end
    endtask

    // Memory model: acks after 0..ack_max idle cycles, pops the scoreboard on
    // each ack and checks the address is held while a request waits.
    always @(negedge clk) begin
        if (rst || !mem_bus.mem_req || stall) begin
            mem_bus.mem_ack = 1'b0;
            if (rst) wait_left = 0;
        end else if (wait_left > 0) begin
            mem_bus.mem_ack = 1'b0;
            wait_left--;
        end else begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = mem_data(mem_bus.mem_addr);
            if (exp_addr.size() == 0) begin
                check("sb_unexpected_req", 32'(mem_bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                check("req_addr", 32'(mem_bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            wait_left = int'($urandom_range(ack_max, 0));
        end
        if (mem_bus.mem_req && prev_req && !prev_ack) begin
            check("addr_stable", 32'(mem_bus.mem_addr), 32'(prev_addr));
        end
        prev_req  = mem_bus.mem_req;
        prev_ack  = mem_bus.mem_ack;
        prev_addr = mem_bus.mem_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger(input logic [2:0] sel, input bit expect_fetch);
        frame_sel = sel;
        if (expect_fetch) begin
            for (int k = 0; k < 75; k++) exp_addr.push_back(12'(int'(sel) * 75 + k));
        end
        Vcnt = 11'd601;
        Hcnt = 11'd0;
        tick();
        Vcnt = 11'd100;
        Hcnt = 11'd5;
    endtask

    task automatic commit();
        Vcnt = 11'd0;
        Hcnt = 11'd0;
        tick();
        Vcnt = 11'd100;
        Hcnt = 11'd5;
    endtask

    task automatic wait_fetch(input int budget, output int cycles);
        cycles = 0;
        while (mem_bus.mem_req && cycles < budget) begin
            tick();
            cycles++;
        end
        check("fetch_done", 32'(mem_bus.mem_req), 32'd0);
        check("sb_drained", 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int req_seen;
        rst = 1'b1; Vcnt = 11'd100; Hcnt = 11'd5; enable = 1'b1; frame_sel = 3'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_player("reset_player", '0);
        check("reset_frame_cur", 32'(frame_cur), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_req", 32'(mem_bus.mem_req), 32'd0);
        check("reset_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        // 1: zero-wait fetch of frame 2
        trigger(3'd2, 1'b1);
        check("t1_req", 32'(mem_bus.mem_req), 32'd1);
        check("t1_first_addr", 32'(mem_bus.mem_addr), 32'd150);
        check("t1_busy", 32'(busy), 32'd1);
        wait_fetch(200, cyc);
        check("t1_fetch_cycles", 32'(cyc), 32'd75);
        check("t1_busy_pending", 32'(busy), 32'd1);
        check_player("t1_no_early_commit", '0);
        commit();
        check_player("t1_player", image(2));
        check("t1_frame_cur", 32'(frame_cur), 32'd2);
        check("t1_busy_low", 32'(busy), 32'd0);

        // 2: same frame again is skipped
        trigger(3'd2, 1'b0);
        req_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (mem_bus.mem_req || busy) req_seen++;
            tick();
        end
        check("t2_no_traffic", 32'(req_seen), 32'd0);
        commit();
        check_player("t2_player", image(2));

        // 3: random ack delay 0-3
        ack_max = 3;
        trigger(3'd4, 1'b1);
        wait_fetch(600, cyc);
        commit();
        check_player("t3_player", image(4));
        check("t3_frame_cur", 32'(frame_cur), 32'd4);

        // 4: acks stalled past frame start, trigger during stall
        ack_max = 0;
        stall = 1'b1;
        trigger(3'd6, 1'b1);
        repeat (5) tick();
        commit();
        check_player("t4_old_kept", image(4));
        check("t4_frame_cur_old", 32'(frame_cur), 32'd4);
        check("t4_busy", 32'(busy), 32'd1);
        trigger(3'd1, 1'b0);
        check("t4_overrun_hi", 32'(overrun), 32'd1);
        tick();
        check("t4_overrun_lo", 32'(overrun), 32'd0);
        stall = 1'b0;
        wait_fetch(200, cyc);
        commit();
        check_player("t4_player", image(6));
        check("t4_frame_cur", 32'(frame_cur), 32'd6);

        // 5: reset at word 40
        trigger(3'd3, 1'b1);
        repeat (40) tick();
        rst = 1'b1;
        #1;
        check("t5_req", 32'(mem_bus.mem_req), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check_player("t5_player", '0);
        exp_addr.delete();
        tick();
        rst = 1'b0;
        tick();
        trigger(3'd3, 1'b1);
        check("t5_restart_addr", 32'(mem_bus.mem_addr), 32'd225);
        wait_fetch(200, cyc);
        commit();
        check_player("t5_player_refetch", image(3));

        // 6: frame_sel change mid-fetch ignored until next trigger
        ack_max = 1;
        trigger(3'd1, 1'b1);
        repeat (10) tick();
        frame_sel = 3'd5;
        wait_fetch(400, cyc);
        commit();
        check("t6_frame_cur", 32'(frame_cur), 32'd1);
        check_player("t6_player", image(1));
        trigger(3'd5, 1'b1);
        check("t6_addr_375", 32'(mem_bus.mem_addr), 32'd375);
        wait_fetch(400, cyc);
        commit();
        check("t6_frame_cur5", 32'(frame_cur), 32'd5);
        check_player("t6_player5", image(5));

        // enable low: no fetch starts, address holds its last value
        enable = 1'b0;
        trigger(3'd2, 1'b0);
        check("en_req", 32'(mem_bus.mem_req), 32'd0);
        check("en_busy", 32'(busy), 32'd0);
        check("en_addr_hold", 32'(mem_bus.mem_addr), 32'd449);
        enable = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
